pll_dyn_reconfig: RTL and testbench

Sequencer for a PLLVR instance used with DYN_FBDIV_SEL/DYN_IDIV_SEL = "true". It drives the FBDSEL/IDSEL codes and RESET, then confirms lock, retries on timeout and reports status. New divider settings are accepted through a valid/ready request port. It runs on the PLL reference clock domain, never on a PLL output clock.

---
 rtl/pll_dyn_reconfig.sv | 172 +++++++++++++++++
 tb/tb_pll_dyn_reconfig.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pll_dyn_reconfig.sv
// Lock/reset sequencer for a PLL with dynamically selected FBDSEL/IDSEL codes.
// Runs on the PLL reference clock; retries lock a bounded number of times.
module pll_dyn_reconfig #(
  parameter logic [5:0] FDIV_RESET   = 6'd12,
  parameter logic [5:0] IDIV_RESET   = 6'd5,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         MAX_RETRY    = 3,
  parameter int         LOCK_STABLE  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_fdiv,
  input  logic [5:0] req_idiv,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] fdiv,
  output logic [5:0] idiv,
  output logic       locked,
  output logic       busy,
  output logic       err,
  output logic       done
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT);
  localparam int RT_W = $clog2(MAX_RETRY + 1);
  localparam int SC_W = $clog2(LOCK_STABLE + 1);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);
  localparam logic [SC_W-1:0] SC_DONE = SC_W'(LOCK_STABLE);

  typedef enum logic [2:0] {
    RST_HOLD, WAIT_LOCK, STABLE, LOCKED, ERROR
  } state_t;

  state_t          r_state;
  logic [RC_W-1:0] r_rcnt;
  logic [TO_W-1:0] r_tcnt;
  logic [RT_W-1:0] r_retry;
  logic [SC_W-1:0] r_scnt;
  logic            r_lock_meta, r_lock_s;
  logic            r_pll_reset, r_locked, r_busy, r_err, r_req_ready, r_done;
  logic [5:0]      r_fdiv, r_idiv;

  logic w_accept, w_timeout, w_last_try;
  assign w_accept   = req_valid && r_req_ready;
  assign w_timeout  = (r_tcnt == TO_LAST);
  assign w_last_try = (r_retry == RT_LAST);

  // pll_lock is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_HOLD;
      r_rcnt      <= '0;
      r_tcnt      <= '0;
      r_retry     <= '0;
      r_scnt      <= '0;
      r_pll_reset <= 1'b1;
      r_fdiv      <= FDIV_RESET;
      r_idiv      <= IDIV_RESET;
      r_locked    <= 1'b0;
      r_busy      <= 1'b1;
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        RST_HOLD: begin
          if (r_rcnt == RC_LAST) begin
            r_state     <= WAIT_LOCK;
            r_pll_reset <= 1'b0;
            r_tcnt      <= '0;
            r_scnt      <= '0;
          end else begin
            r_rcnt <= r_rcnt + RC_W'(1);
          end
        end
        // Timeout window spans both states and survives lock glitches
        WAIT_LOCK, STABLE: begin
          if (w_timeout) begin
            r_scnt      <= '0;
            r_pll_reset <= 1'b1;
            if (w_last_try) begin
              r_state     <= ERROR;
              r_err       <= 1'b1;
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_state <= RST_HOLD;
              r_retry <= r_retry + RT_W'(1);
              r_rcnt  <= '0;
            end
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
            if (!r_lock_s) begin
              r_state <= WAIT_LOCK;
              r_scnt  <= '0;
            end else if (r_state == WAIT_LOCK) begin
              r_state <= STABLE;
              r_scnt  <= SC_W'(1);
            end else if (r_scnt == SC_DONE) begin
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_scnt <= r_scnt + SC_W'(1);
            end
          end
        end
        LOCKED, ERROR: begin
          if (w_accept) begin
            r_state     <= RST_HOLD;
            r_fdiv      <= req_fdiv;
            r_idiv      <= req_idiv;
            r_retry     <= '0;
            r_rcnt      <= '0;
            r_pll_reset <= 1'b1;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
          end else if (r_state == LOCKED && !r_lock_s) begin
            // Auto-relock: keep PLL out of reset and reuse the current codes
            r_state     <= WAIT_LOCK;
            r_locked    <= 1'b0;
            r_retry     <= '0;
            r_tcnt      <= '0;
            r_scnt      <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= RST_HOLD;
          r_rcnt      <= '0;
          r_pll_reset <= 1'b1;
          r_locked    <= 1'b0;
          r_busy      <= 1'b1;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset = r_pll_reset;
  assign fdiv      = r_fdiv;
  assign idiv      = r_idiv;
  assign locked    = r_locked;
  assign busy      = r_busy;
  assign err       = r_err;
  assign req_ready = r_req_ready;
  assign done      = r_done;

endmodule

// File: tb/tb_pll_dyn_reconfig.sv
// Directed bench for pll_dyn_reconfig: a vector table for the main flows,
// then hand-written sequences for glitch, lock loss and async reset cases.
module tb_pll_dyn_reconfig;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_fdiv, req_idiv;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] fdiv, idiv;
  logic       locked, busy, err, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll_dyn_reconfig #(
    .FDIV_RESET(6'd12), .IDIV_RESET(6'd5), .RST_CYCLES(4),
    .LOCK_TIMEOUT(32), .MAX_RETRY(2), .LOCK_STABLE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fdiv(req_fdiv), .req_idiv(req_idiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .fdiv(fdiv), .idiv(idiv),
    .locked(locked), .busy(busy), .err(err), .done(done)
  );

  typedef struct {
    string       nm;
    int          n;
    logic        v;
    logic [5:0]  rf;
    logic [5:0]  ri;
    logic        lk;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed status: {pll_reset, fdiv, idiv, locked, busy, err, req_ready, done}
  function automatic logic [17:0] st(input logic pr, input logic [5:0] f,
                                     input logic [5:0] i, input logic lk,
                                     input logic b, input logic e,
                                     input logic r, input logic d);
    return {pr, f, i, lk, b, e, r, d};
  endfunction

  task automatic add(input string nm, input int n, input logic v,
                     input logic [5:0] rf, input logic [5:0] ri,
                     input logic lk, input logic [17:0] e);
    vec_t t;
    t.nm = nm; t.n = n; t.v = v; t.rf = rf; t.ri = ri; t.lk = lk; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [17:0] e);
    logic [17:0] a;
    a = {pll_reset, fdiv, idiv, locked, busy, err, req_ready, done};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got rst=%b f=%0d i=%0d lk=%b bsy=%b err=%b rdy=%b dn=%b, want rst=%b f=%0d i=%0d lk=%b bsy=%b err=%b rdy=%b dn=%b",
               nm, a[17], a[16:11], a[10:5], a[4], a[3], a[2], a[1], a[0],
               e[17], e[16:11], e[10:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  initial begin
    logic [17:0] s_wait_def, s_hold_def;
    s_hold_def = st(1'b1, 6'd12, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    s_wait_def = st(1'b0, 6'd12, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Power-up
    add("hold3",      3, 1'b0, 6'd0,  6'd0,  1'b0, s_hold_def);
    add("rst_fall",   1, 1'b0, 6'd0,  6'd0,  1'b0, s_wait_def);
    add("wait9",      9, 1'b0, 6'd0,  6'd0,  1'b0, s_wait_def);
    add("stab5",      5, 1'b0, 6'd0,  6'd0,  1'b1, s_wait_def);
    add("lock6",      1, 1'b0, 6'd0,  6'd0,  1'b1, st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    add("done_clr",   1, 1'b0, 6'd0,  6'd0,  1'b1, st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    // Reconfig
    add("reconf",     1, 1'b1, 6'd20, 6'd3,  1'b1, st(1'b1, 6'd20, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("rc_hold3",   3, 1'b0, 6'd20, 6'd3,  1'b0, st(1'b1, 6'd20, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("rc_fall",    1, 1'b0, 6'd20, 6'd3,  1'b0, st(1'b0, 6'd20, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("rc_wait9",   9, 1'b0, 6'd20, 6'd3,  1'b0, st(1'b0, 6'd20, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("rc_stab5",   5, 1'b0, 6'd20, 6'd3,  1'b1, st(1'b0, 6'd20, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("rc_lock",    1, 1'b0, 6'd20, 6'd3,  1'b1, st(1'b0, 6'd20, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    add("rc_dclr",    1, 1'b0, 6'd20, 6'd3,  1'b1, st(1'b0, 6'd20, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    // Timeout / retry / error, requests ignored while busy
    add("to_req",     1, 1'b1, 6'd7,  6'd9,  1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_hold3",   3, 1'b0, 6'd7,  6'd9,  1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_fall1",   1, 1'b0, 6'd7,  6'd9,  1'b0, st(1'b0, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_wait31",  31, 1'b0, 6'd7, 6'd9,  1'b0, st(1'b0, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_retry",   1, 1'b0, 6'd7,  6'd9,  1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("ign_hold",   3, 1'b1, 6'd50, 6'd60, 1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_fall2",   1, 1'b0, 6'd50, 6'd60, 1'b0, st(1'b0, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("ign_wait",   31, 1'b1, 6'd50, 6'd60, 1'b0, st(1'b0, 6'd7, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("to_err",     1, 1'b0, 6'd50, 6'd60, 1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add("err_stay",   5, 1'b0, 6'd50, 6'd60, 1'b0, st(1'b1, 6'd7, 6'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add("err_clear",  1, 1'b1, 6'd33, 6'd17, 1'b0, st(1'b1, 6'd33, 6'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    add("post_req",   1, 1'b0, 6'd33, 6'd17, 1'b0, st(1'b1, 6'd33, 6'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    rst_n = 1'b0; req_valid = 1'b0; req_fdiv = 6'd0; req_idiv = 6'd0; pll_lock = 1'b0;
    tick(3);
    chk("reset", s_hold_def);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      req_valid = vecs[k].v;
      req_fdiv  = vecs[k].rf;
      req_idiv  = vecs[k].ri;
      pll_lock  = vecs[k].lk;
      tick(vecs[k].n);
      chk(vecs[k].nm, vecs[k].exp);
    end

    // Async reset in RST_HOLD after a reconfig, between clock edges
    #3 rst_n = 1'b0;
    #1 chk("async_rst", s_hold_def);
    tick(2);
    rst_n = 1'b1;

    // Glitch in STABLE: lock_s high 2, low 1, then high
    tick(4);
    chk("gl_fall", s_wait_def);
    tick(2);
    pll_lock = 1'b1; tick(2);
    pll_lock = 1'b0; tick(1);
    pll_lock = 1'b1; tick(5);
    chk("gl_no_lock", s_wait_def);
    tick(1);
    chk("gl_lock", st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));

    // Lock loss -> auto-relock path, no PLL reset
    pll_lock = 1'b0; tick(2);
    chk("ll_hold", st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(1);
    chk("ll_drop", s_wait_def);

    // Timeout counter keeps running across a glitch
    tick(24);
    pll_lock = 1'b1; tick(2);
    pll_lock = 1'b0; tick(1);
    pll_lock = 1'b1; tick(4);
    chk("nr_pre", s_wait_def);
    tick(1);
    chk("nr_timeout", s_hold_def);

    // Relock after retry, then lock loss must clear the retry count
    pll_lock = 1'b0; tick(4);
    chk("rl_fall", s_wait_def);
    pll_lock = 1'b1; tick(6);
    chk("rl_lock", st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    pll_lock = 1'b0; tick(3);
    chk("ll2_drop", s_wait_def);
    tick(31);
    chk("ll2_wait", s_wait_def);
    tick(1);
    chk("ll2_retry", s_hold_def);

    // Request and lock loss seen on the same edge: request wins
    tick(4);
    chk("sim_fall", s_wait_def);
    pll_lock = 1'b1; tick(6);
    chk("sim_lock", st(1'b0, 6'd12, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    pll_lock = 1'b0; tick(2);
    req_valid = 1'b1; req_fdiv = 6'd40; req_idiv = 6'd2;
    tick(1);
    chk("sim_req", st(1'b1, 6'd40, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    req_valid = 1'b0;
    tick(1);
    chk("sim_after", st(1'b1, 6'd40, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
